// File: rtl/zx_loader_pkg.sv
// Shared definitions for the ZX80/ZX81 ioctl loader: file types, E_LINE
// header offsets and the loader state encoding.
package zx_loader_pkg;

   // File type as carried in ioctl_index[2:0]
   localparam logic [2:0] FT_ROM = 3'd0;
   localparam logic [2:0] FT_P   = 3'd1;
   localparam logic [2:0] FT_O   = 3'd2;

   // File offsets of the E_LINE system variable inside the tape image
   localparam logic [26:0] P_ELINE_LO = 27'h00B;
   localparam logic [26:0] P_ELINE_HI = 27'h00C;
   localparam logic [26:0] O_ELINE_LO = 27'h00A;
   localparam logic [26:0] O_ELINE_HI = 27'h00B;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // .p and .o images carry an E_LINE header; ROM images do not
   function automatic logic is_prog_type(input logic [2:0] t);
      return (t == FT_P) || (t == FT_O);
   endfunction

   function automatic logic [26:0] eline_lo_ofs(input logic [2:0] t);
      return (t == FT_P) ? P_ELINE_LO : O_ELINE_LO;
   endfunction

   function automatic logic [26:0] eline_hi_ofs(input logic [2:0] t);
      return (t == FT_P) ? P_ELINE_HI : O_ELINE_HI;
   endfunction

endpackage

// File: rtl/zx_loader_fifo.sv
// Small synchronous FIFO between the ioctl byte stream and the memory port.
// The head entry is visible combinationally so a byte pushed into an empty
// FIFO is presented on the memory port on the following cycle. A push is
// accepted while full when a pop happens in the same cycle.
module zx_loader_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 24
) (
   input  logic             clk_sys,
   input  logic             reset,
   input  logic             clr,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   // Extra pointer bit distinguishes full from empty when indices match
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head  = mem_q[rd_ptr_q[AW-1:0]];

   // Accept/advance decisions; a pop frees the slot a full-FIFO push needs
   always_comb begin
      do_pop   = pop & ~empty;
      do_push  = push & (~full | do_pop);
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end
   end

   // Pointer registers
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage; contents need no reset since the pointers define validity
   always_ff @(posedge clk_sys) begin
      if (do_push && !clr)
         mem_q[wr_ptr_q[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/zx_ioctl_loader.sv
// ZX80/ZX81 ioctl download loader. Maps incoming file bytes to Z80
// addresses by file type, buffers them, writes them through a req/ack
// memory port while holding the CPU, and reports length/error/completion.
// The ioctl stream cannot be throttled, so overflow is flagged, not stalled.
module zx_ioctl_loader
   import zx_loader_pkg::*;
#(
   parameter int          FIFO_DEPTH = 4,
   parameter logic [15:0] ROM_BASE   = 16'h0000,
   parameter logic [15:0] ROM_MAX    = 16'h2000,
   parameter logic [15:0] P_BASE     = 16'h4009,
   parameter logic [15:0] O_BASE     = 16'h4000
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic [15:0] ioctl_index,
   input  logic        ioctl_wr,
   input  logic [26:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_data,
   input  logic        mem_ack,
   output logic        cpu_hold,
   output logic [1:0]  load_type,
   output logic [15:0] load_len,
   output logic        load_done,
   output logic        load_err
);

   state_t      state_q, state_d;
   logic        dl_prev_q;
   logic [2:0]  type_q, type_d;
   logic [1:0]  load_type_q, load_type_d;
   logic [15:0] load_len_q, load_len_d;
   logic        load_err_q, load_err_d;
   logic [15:0] eline_q, eline_d;
   logic        eline_lo_q, eline_lo_d;
   logic        eline_hi_q, eline_hi_d;
   logic [15:0] hi_tgt_q, hi_tgt_d;

   logic        dl_rise, dl_fall;
   logic [15:0] base;
   logic [15:0] target;
   logic        prog_type, type_ok;
   logic        hit_lo, hit_hi;
   logic        byte_drop;
   logic        fifo_clr, fifo_push, fifo_pop;
   logic        fifo_full, fifo_empty;
   logic [23:0] fifo_head;
   logic        unused_index;

   assign unused_index = ^ioctl_index[15:3];

   assign dl_rise   = ioctl_download & ~dl_prev_q;
   assign dl_fall   = ~ioctl_download & dl_prev_q;
   assign prog_type = is_prog_type(type_q);
   assign type_ok   = (type_q <= FT_O);
   assign target    = base + ioctl_addr[15:0];
   assign hit_lo    = prog_type && (ioctl_addr == eline_lo_ofs(type_q));
   assign hit_hi    = prog_type && (ioctl_addr == eline_hi_ofs(type_q));

   // Load base address for the latched file type
   always_comb begin
      base = ROM_BASE;
      case (type_q)
         FT_P:    base = P_BASE;
         FT_O:    base = O_BASE;
         default: base = ROM_BASE;
      endcase
   end

   // Bytes that fall outside the image's valid window are discarded
   always_comb begin
      byte_drop = 1'b0;
      if (!type_ok)
         byte_drop = 1'b1;
      if (ioctl_addr[26:16] != 11'd0)
         byte_drop = 1'b1;
      if ((type_q == FT_ROM) && (ioctl_addr[15:0] >= ROM_MAX))
         byte_drop = 1'b1;
      if (prog_type && eline_lo_q && eline_hi_q && (target >= eline_q))
         byte_drop = 1'b1;
   end

   // Memory port is driven straight from the FIFO head; reset kills it at once
   assign mem_we   = ~fifo_empty & ~reset;
   assign mem_addr = fifo_head[23:8];
   assign mem_data = fifo_head[7:0];
   assign fifo_pop = mem_we & mem_ack;

   assign cpu_hold  = (state_q == ST_LOAD) || (state_q == ST_FLUSH);
   assign load_done = (state_q == ST_DONE);
   assign load_type = load_type_q;
   assign load_len  = load_len_q;
   assign load_err  = load_err_q;

   // Next-state and session bookkeeping
   always_comb begin
      state_d     = state_q;
      type_d      = type_q;
      load_type_d = load_type_q;
      load_len_d  = load_len_q;
      load_err_d  = load_err_q;
      eline_d     = eline_q;
      eline_lo_d  = eline_lo_q;
      eline_hi_d  = eline_hi_q;
      hi_tgt_d    = hi_tgt_q;
      fifo_clr    = 1'b0;
      fifo_push   = 1'b0;

      if (fifo_pop && (load_len_q != 16'hFFFF))
         load_len_d = load_len_q + 16'd1;

      case (state_q)
         ST_IDLE: begin
            if (dl_rise) begin
               state_d     = ST_LOAD;
               type_d      = ioctl_index[2:0];
               load_type_d = ioctl_index[1:0];
               load_len_d  = 16'd0;
               load_err_d  = (ioctl_index[2:0] > FT_O);
               eline_d     = 16'd0;
               eline_lo_d  = 1'b0;
               eline_hi_d  = 1'b0;
               hi_tgt_d    = 16'd0;
               fifo_clr    = 1'b1;
            end
         end

         ST_LOAD: begin
            if (ioctl_wr) begin
               fifo_push = ~byte_drop;
               if (!byte_drop && fifo_full && !fifo_pop)
                  load_err_d = 1'b1;
               if (hit_lo) begin
                  eline_d[7:0] = ioctl_dout;
                  eline_lo_d   = 1'b1;
               end
               if (hit_hi) begin
                  eline_d[15:8] = ioctl_dout;
                  eline_hi_d    = 1'b1;
                  hi_tgt_d      = target;
               end
               // E_LINE must lie beyond the header byte that holds it
               if ((hit_lo || hit_hi) && eline_lo_d && eline_hi_d &&
                   ({1'b0, eline_d} < ({1'b0, hi_tgt_d} + 17'd1)))
                  load_err_d = 1'b1;
            end
            if (dl_fall) begin
               state_d = ST_FLUSH;
               if (prog_type && !(eline_lo_d && eline_hi_d))
                  load_err_d = 1'b1;
            end
         end

         ST_FLUSH: begin
            if (ioctl_wr)
               load_err_d = 1'b1;
            if (fifo_empty)
               state_d = ST_DONE;
         end

         ST_DONE: state_d = ST_IDLE;

         default: state_d = ST_IDLE;
      endcase
   end

   // State and session registers
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         dl_prev_q   <= 1'b0;
         type_q      <= FT_ROM;
         load_type_q <= 2'd0;
         load_len_q  <= 16'd0;
         load_err_q  <= 1'b0;
         eline_q     <= 16'd0;
         eline_lo_q  <= 1'b0;
         eline_hi_q  <= 1'b0;
         hi_tgt_q    <= 16'd0;
      end else begin
         state_q     <= state_d;
         dl_prev_q   <= ioctl_download;
         type_q      <= type_d;
         load_type_q <= load_type_d;
         load_len_q  <= load_len_d;
         load_err_q  <= load_err_d;
         eline_q     <= eline_d;
         eline_lo_q  <= eline_lo_d;
         eline_hi_q  <= eline_hi_d;
         hi_tgt_q    <= hi_tgt_d;
      end
   end

   zx_loader_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (24)
   ) u_fifo (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .clr       (fifo_clr),
      .push      (fifo_push),
      .push_data ({target, ioctl_dout}),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

endmodule

// File: tb/tb_zx_ioctl_loader.sv
// Bench for zx_ioctl_loader: directed sessions plus randomized sessions,
// checked every cycle against a queue-based model of the loader rules.
module tb_zx_ioctl_loader;

   localparam int DEPTH = 4;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        ioctl_download;
   logic [15:0] ioctl_index;
   logic        ioctl_wr;
   logic [26:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_data;
   logic        mem_ack;
   logic        cpu_hold;
   logic [1:0]  load_type;
   logic [15:0] load_len;
   logic        load_done;
   logic        load_err;

   int tests_run    = 0;
   int tests_failed = 0;
   int done_cnt     = 0;
   int wr_cnt       = 0;
   bit cmp_en       = 0;
   bit ack_rand     = 0;

   // Reference model: session phase, pending writes, session results
   // phase: 0 idle, 1 receiving, 2 draining, 3 reporting completion
   int          m_phase  = 0;
   bit          m_prev_dl = 0;
   int          m_type   = 0;
   int          m_ltype  = 0;
   int unsigned m_len    = 0;
   bit          m_err    = 0;
   int          m_eline  = 0;
   bit          m_lo_ok  = 0;
   bit          m_hi_ok  = 0;
   int          m_hi_tgt = 0;
   logic [23:0] m_q[$];

   zx_ioctl_loader #(
      .FIFO_DEPTH (DEPTH),
      .ROM_BASE   (16'h0000),
      .ROM_MAX    (16'h2000),
      .P_BASE     (16'h4009),
      .O_BASE     (16'h4000)
   ) dut (
      .clk_sys        (clk_sys),
      .reset          (reset),
      .ioctl_download (ioctl_download),
      .ioctl_index    (ioctl_index),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_data       (mem_data),
      .mem_ack        (mem_ack),
      .cpu_hold       (cpu_hold),
      .load_type      (load_type),
      .load_len       (load_len),
      .load_done      (load_done),
      .load_err       (load_err)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // One file byte arriving during a session
   task automatic model_byte(input int n, input bit popped);
      int  off, base, tgt, lo_off;
      bit  prog, keep, captured;
      off = int'(ioctl_addr);
      if (m_type > 2) return;
      prog   = (m_type != 0);
      base   = (m_type == 1) ? 'h4009 : (m_type == 2) ? 'h4000 : 0;
      tgt    = (base + (off % 'h10000)) % 'h10000;
      lo_off = (m_type == 1) ? 'h0B : 'h0A;
      keep   = (off < 'h10000) &&
               !(m_type == 0 && off >= 'h2000) &&
               !(prog && m_lo_ok && m_hi_ok && tgt >= m_eline);
      captured = 0;
      if (prog && off == lo_off) begin
         m_eline  = (m_eline / 256) * 256 + int'(ioctl_dout);
         m_lo_ok  = 1;
         captured = 1;
      end
      if (prog && off == lo_off + 1) begin
         m_eline  = int'(ioctl_dout) * 256 + (m_eline % 256);
         m_hi_ok  = 1;
         m_hi_tgt = tgt;
         captured = 1;
      end
      if (captured && m_lo_ok && m_hi_ok && m_eline < m_hi_tgt + 1)
         m_err = 1;
      if (keep) begin
         if (n == DEPTH && !popped) m_err = 1;
         else m_q.push_back({tgt[15:0], ioctl_dout});
      end
   endtask

   // Advance the model by one clock using the inputs sampled at that edge
   task automatic model_step();
      int n;
      bit popped;
      n = m_q.size();
      if (reset) begin
         m_phase = 0; m_prev_dl = 0; m_type = 0; m_ltype = 0; m_len = 0;
         m_err = 0; m_eline = 0; m_lo_ok = 0; m_hi_ok = 0; m_hi_tgt = 0;
         m_q.delete();
         return;
      end
      popped = (n > 0) && (mem_ack === 1'b1);
      case (m_phase)
         0: if (ioctl_download && !m_prev_dl) begin
               m_phase = 1;
               m_type  = int'(ioctl_index[2:0]);
               m_ltype = m_type % 4;
               m_len   = 0;
               m_err   = (m_type > 2);
               m_eline = 0; m_lo_ok = 0; m_hi_ok = 0; m_hi_tgt = 0;
               m_q.delete();
            end
         1: begin
               if (ioctl_wr) model_byte(n, popped);
               if (!ioctl_download && m_prev_dl) begin
                  m_phase = 2;
                  if ((m_type == 1 || m_type == 2) && !(m_lo_ok && m_hi_ok)) m_err = 1;
               end
            end
         2: begin
               if (ioctl_wr) m_err = 1;
               if (n == 0) m_phase = 3;
            end
         default: m_phase = 0;
      endcase
      if (popped) begin
         void'(m_q.pop_front());
         if (m_len < 65535) m_len++;
      end
      m_prev_dl = ioctl_download;
   endtask

   task automatic cycle();
      @(posedge clk_sys);
      #1;
      model_step();
      if (ack_rand) mem_ack = ($urandom_range(0, 2) != 0);
   endtask

   // Compare DUT outputs with the model mid-cycle
   always @(negedge clk_sys) begin
      if (cmp_en) begin
         bit e_we;
         e_we = (m_q.size() > 0) && !reset;
         check("mem_we", {31'd0, mem_we}, {31'd0, e_we});
         if (e_we) begin
            check("mem_addr", {16'd0, mem_addr}, {16'd0, m_q[0][23:8]});
            check("mem_data", {24'd0, mem_data}, {24'd0, m_q[0][7:0]});
         end
         check("cpu_hold", {31'd0, cpu_hold}, (m_phase == 1 || m_phase == 2) ? 1 : 0);
         check("load_done", {31'd0, load_done}, (m_phase == 3) ? 1 : 0);
         check("load_type", {30'd0, load_type}, m_ltype);
         check("load_len", {16'd0, load_len}, m_len);
         check("load_err", {31'd0, load_err}, {31'd0, m_err});
         if (load_done === 1'b1) done_cnt++;
         if (mem_we === 1'b1 && mem_ack === 1'b1) wr_cnt++;
      end
   end

   task automatic begin_session(input int idx);
      done_cnt       = 0;
      wr_cnt         = 0;
      ioctl_index    = idx[15:0];
      ioctl_download = 1;
      cycle();
      cycle();
   endtask

   task automatic send_byte(input int off, input int d, input int gap);
      ioctl_wr   = 1;
      ioctl_addr = off[26:0];
      ioctl_dout = d[7:0];
      cycle();
      ioctl_wr = 0;
      repeat (gap) cycle();
   endtask

   task automatic end_session(input bit flush_wr);
      int k;
      ioctl_download = 0;
      cycle();
      if (flush_wr && load_done !== 1'b1) begin
         ioctl_wr = 1;
         cycle();
         ioctl_wr = 0;
      end
      for (k = 0; k < 400 && load_done !== 1'b1; k++) cycle();
      check("session_done_seen", {31'd0, load_done}, 1);
      cycle();
      cycle();
   endtask

   task automatic random_session();
      int t, r, n, off, d;
      r = $urandom_range(0, 9);
      t = (r < 3) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : $urandom_range(3, 7);
      n = $urandom_range(4, 30);
      ack_rand = 1;
      begin_session(t);
      off = 0;
      for (int i = 0; i < n; i++) begin
         r = $urandom_range(0, 15);
         if (r == 0) off = $urandom_range(0, 'h2100);
         else if (r == 1) off = off + 'h10000;
         d = $urandom_range(0, 255);
         if ((t == 1 && off == 'h0C) || (t == 2 && off == 'h0B)) d = $urandom_range('h40, 'h41);
         send_byte(off, d, $urandom_range(0, 2));
         off = (off % 'h10000) + 1;
      end
      end_session($urandom_range(0, 2) == 0);
      ack_rand = 0;
      mem_ack  = 1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1; ioctl_download = 0; ioctl_index = 0; ioctl_wr = 0;
      ioctl_addr = 0; ioctl_dout = 0; mem_ack = 1;
      cycle();
      cmp_en = 1;
      cycle();
      reset = 0;
      cycle();
      check("rst_mem_we", {31'd0, mem_we}, 0);
      check("rst_cpu_hold", {31'd0, cpu_hold}, 0);
      check("rst_load_len", {16'd0, load_len}, 0);
      check("rst_load_err", {31'd0, load_err}, 0);
      check("rst_load_type", {30'd0, load_type}, 0);

      // ROM: 16 bytes at offsets 0..15, ack always granted
      begin_session(0);
      for (int i = 0; i < 16; i++) send_byte(i, 'hA0 + i, 0);
      end_session(0);
      check("rom_len", {16'd0, load_len}, 16);
      check("rom_model_len", m_len, 16);
      check("rom_err", {31'd0, load_err}, 0);
      check("rom_writes", wr_cnt, 16);
      check("rom_done_pulses", done_cnt, 1);

      // .p: E_LINE = 0x4018 truncates the image after target 0x4017
      begin_session(1);
      for (int i = 0; i < 20; i++)
         send_byte(i, (i == 'h0B) ? 'h18 : (i == 'h0C) ? 'h40 : i + 1, 0);
      end_session(0);
      check("p_len", {16'd0, load_len}, 15);
      check("p_err", {31'd0, load_err}, 0);
      check("p_type", {30'd0, load_type}, 1);
      check("p_writes", wr_cnt, 15);

      // ROM offsets beyond the window are silently dropped
      begin_session(0);
      send_byte('h2000, 'h11, 1);
      send_byte('h10000, 'h22, 1);
      send_byte('h10003, 'h33, 1);
      end_session(0);
      check("rom_oob_len", {16'd0, load_len}, 0);
      check("rom_oob_err", {31'd0, load_err}, 0);
      check("rom_oob_writes", wr_cnt, 0);

      // Burst of 6 with memory stalled: 4 buffered, 2 lost
      mem_ack = 0;
      begin_session(0);
      for (int i = 0; i < 6; i++) send_byte(i, 'h50 + i, 0);
      repeat (10) cycle();
      mem_ack = 1;
      end_session(0);
      check("ovf_len", {16'd0, load_len}, 4);
      check("ovf_err", {31'd0, load_err}, 1);
      check("ovf_writes", wr_cnt, 4);

      // .o without E_LINE: all bytes written, error at end of download
      begin_session(2);
      for (int i = 0; i < 8; i++) send_byte(i, 'h70 + i, 1);
      end_session(0);
      check("o_len", {16'd0, load_len}, 8);
      check("o_err", {31'd0, load_err}, 1);
      check("o_type", {30'd0, load_type}, 2);
      check("o_done_pulses", done_cnt, 1);

      for (int s = 0; s < 12; s++) random_session();

      // Reset in the middle of a session with two writes pending
      mem_ack = 0;
      begin_session(0);
      send_byte(0, 'h01, 0);
      send_byte(1, 'h02, 0);
      cycle();
      reset = 1;
      ioctl_download = 0;
      cycle();
      reset = 0;
      check("rstmid_mem_we", {31'd0, mem_we}, 0);
      check("rstmid_cpu_hold", {31'd0, cpu_hold}, 0);
      check("rstmid_load_len", {16'd0, load_len}, 0);
      cycle();
      cycle();
      check("rstmid_done_pulses", done_cnt, 0);
      check("rstmid_mem_we_later", {31'd0, mem_we}, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
